// File: rtl/instruction_decode_stage_pkg.sv
// Shared decode definitions: opcode constants, instruction field positions
// and the decode-stage FSM state encoding.
package instruction_decode_stage_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 28;
  localparam int RD_MSB    = 27;
  localparam int RD_LSB    = 24;
  localparam int RS1_MSB   = 23;
  localparam int RS1_LSB   = 20;
  localparam int RS2_MSB   = 19;
  localparam int RS2_LSB   = 16;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_MSB = 7;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALTED
  } dec_state_e;

endpackage

// File: rtl/instruction_decode_stage_fifo.sv
// decode_fifo: DEPTH-entry FIFO of raw instruction words. The head is read
// combinationally so a push is visible on the cycle after it is written.
module decode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode stage: edge-detects fetch handshakes, filters NOP/JMP/HALT through a
// RUN/FLUSH/HALTED FSM and queues decoded instructions for execute.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readyFlag,
  input  logic [31:0] instructionInput,
  input  logic        decReady,
  output logic        decValid,
  output logic [3:0]  decOpcode,
  output logic [3:0]  decRd,
  output logic [3:0]  decRs1,
  output logic [3:0]  decRs2,
  output logic [15:0] decImm,
  output logic        parallelFlag,
  output logic [7:0]  parallelAddress,
  output logic        overflow,
  output logic        halted
);

  dec_state_e  state;
  dec_state_e  state_nxt;
  logic        ready_q;
  logic        capture;
  logic        push;
  logic        pop;
  logic        jump_req;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic [3:0]  opcode_in;

  assign capture   = readyFlag && !ready_q;
  assign opcode_in = instructionInput[OPC_MSB:OPC_LSB];
  assign pop       = decValid && decReady;
  assign decValid  = !empty;
  assign halted    = (state == ST_HALTED);

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    jump_req  = 1'b0;
    case (state)
      ST_RUN: begin
        if (capture) begin
          case (opcode_in)
            OP_NOP: ;
            OP_JMP: begin
              jump_req  = 1'b1;
              state_nxt = ST_FLUSH;
            end
            OP_HALT: begin
              push      = 1'b1;
              state_nxt = ST_HALTED;
            end
            default: push = 1'b1;
          endcase
        end
      end
      // The capture already in flight before the PC reload is swallowed.
      ST_FLUSH:  if (capture) state_nxt = ST_RUN;
      ST_HALTED: ;
      default:   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_RUN;
      ready_q         <= 1'b0;
      parallelFlag    <= 1'b0;
      parallelAddress <= '0;
      overflow        <= 1'b0;
    end else begin
      state        <= state_nxt;
      ready_q      <= readyFlag;
      parallelFlag <= jump_req;
      if (jump_req) parallelAddress <= instructionInput[JADDR_MSB:0];
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (instructionInput),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign decOpcode = head[OPC_MSB:OPC_LSB];
  assign decRd     = head[RD_MSB:RD_LSB];
  assign decRs1    = head[RS1_MSB:RS1_LSB];
  assign decRs2    = head[RS2_MSB:RS2_LSB];
  assign decImm    = head[IMM_MSB:IMM_LSB];

endmodule

// File: doc/instruction_decode_stage.md
INSTRUCTION_DECODE_STAGE -- requirements
Module: instruction_decode_stage

Interface
REQ-001 Parameter: DEPTH, 2, number of entries in the decoded-instruction queue (power of two, 2..8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 readyFlag  input  1  fetch stage: assembled instruction valid on instructionInput.
REQ-005 instructionInput  input  32  assembled instruction from fetch stage.
REQ-006 decReady  input  1  execute stage can accept the head entry this cycle.
REQ-007 decValid  output  1  queue head holds a valid decoded instruction.
REQ-008 decOpcode  output  4  head opcode, bits [31:28].
REQ-009 decRd / decRs1 / decRs2  output  4 each  head fields, bits [27:24] / [23:20] / [19:16].
REQ-010 decImm  output  16  head immediate, bits [15:0], zero-extended by consumer.
REQ-011 parallelFlag  output  1  one-cycle jump request to fetch program counter.
REQ-012 parallelAddress  output  8  jump target, valid while parallelFlag=1.
REQ-013 overflow  output  1  sticky: an instruction was dropped because the queue was full.
REQ-014 halted  output  1  HALT decoded; no further instructions accepted.

Function
REQ-015 Capture event SHALL be readyFlag=1 in this cycle and readyFlag=0 in the previous registered cycle (rising-edge detect); a level held high SHALL capture once.
REQ-016 Opcode 0x0 (NOP) on capture SHALL be discarded, no queue push.
REQ-017 Opcode 0xE (JMP) on capture SHALL NOT be pushed; next cycle parallelFlag=1 for exactly one cycle with parallelAddress=instructionInput[7:0].
REQ-018 Opcode 0xF (HALT) on capture SHALL be pushed like a normal instruction and SHALL move the FSM to HALTED.
REQ-019 Opcodes 0x1..0xD SHALL be pushed unmodified; field slices per REQ-008..010.
REQ-020 FSM states RUN, FLUSH, HALTED; RUN: capture per REQ-016..019; JMP -> FLUSH; HALT -> HALTED.
REQ-021 FLUSH SHALL discard exactly the next capture event (instruction in flight before PC reload), then return to RUN; no push, no jump, no halt.
REQ-022 HALTED SHALL ignore all captures; the queue SHALL continue draining to the consumer; exit only by reset.
REQ-023 Queue SHALL be FIFO, DEPTH entries; pop when decValid=1 and decReady=1.
REQ-024 Push latency: instruction captured in cycle N SHALL be visible at head with decValid=1 in cycle N+1 if queue was empty.
REQ-025 Push while full without simultaneous pop SHALL drop the new instruction and set overflow=1 (sticky until reset); FSM transitions for HALT still apply.
REQ-026 Push and pop in the same cycle when full SHALL succeed, occupancy unchanged, no overflow.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-028 Outputs decOpcode..decImm SHALL be don't-care while decValid=0 but SHALL be stable while decValid=1 and decReady=0.

Reset
REQ-029 On rst=1, immediately: FSM=RUN, queue empty, decValid=0, parallelFlag=0, parallelAddress=0, overflow=0, halted=0, edge-detect register=0.
REQ-030 Reset mid-operation SHALL discard all queued entries and any pending jump; first capture after reset release follows RUN rules.

Structure
REQ-031 Shared package SHALL hold opcode constants (NOP, JMP, HALT), field bit positions, and the FSM state enum.
REQ-032 The queue SHALL be a separate sub-module decode_fifo (parameter DEPTH, WIDTH=32), with push/pop/full/empty ports.

Verification
REQ-033 Captures 0x1234_5678, 0x2000_0001 with decReady=1 -> decValid pulses, decOpcode=1 then 2, decImm=0x5678 then 0x0001, overflow=0.
REQ-034 Capture 0xE000_0042 -> next cycle parallelFlag=1 for 1 cycle, parallelAddress=0x42; following capture 0x3000_0000 dropped; next 0x4000_0000 queued.
REQ-035 decReady=0, DEPTH=2, three captures 0x1/0x2/0x3 opcodes -> first two held in order, third dropped, overflow=1 and stays 1.
REQ-036 Capture 0xF000_0000 then 0x1000_0000 -> HALT reaches head, halted=1, second instruction never appears.
REQ-037 readyFlag held high 5 cycles with 0x5000_0000 -> exactly one push.
REQ-038 rst asserted with 2 queued entries and pending jump -> same cycle decValid=0, parallelFlag=0, halted=0, overflow=0.
